addr_latch_demux8: RTL and testbench
====================================

Name: addr_latch_demux8

Overview:
- Clocked 8-bit addressable latch / 1-to-8 demultiplexer. It is the receiving end of an 8:1 mux link: a remote 8:1 mux serializes a byte, with its select lines driven by this block's sel_out, and this block rebuilds the byte.
- Two operating styles:
  - Direct mode: the address comes from the sel input, with '259-style control modes.
  - Scan mode: an internal 3-bit counter walks the addresses and a frame is assembled into a parallel word.

Parameters:
- TPD, 0, output propagation delay in ns, applied to q, word, word_valid and sel_out (simulation only; 1ns timescale).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- en  input  1  write enable, active-high
- clr  input  1  synchronous clear/demux select, active-high
- scan  input  1  1 = address from internal counter; 0 = address from sel
- sel  input  3  external address {c,b,a}; bit 2 = c
- d  input  1  serial data bit
- q  output  8  latch outputs
- sel_out  output  3  current counter value; drives the remote mux c,b,a
- word  output  8  last completed scan frame
- word_valid  output  1  one-cycle pulse when word updates

Behaviour:
- Reset (rst=1, asynchronous, dominates everything): q=8'h00, cnt=0, sel_out=0, word=8'h00, word_valid=0. All state is held while rst=1.
- Effective address: addr = scan ? cnt : sel.
- All updates occur on the rising clk edge. Latency is 1 clock from input to outputs.
- Mode decode on {clr,en} each edge:
  - 00 memory: q holds.
  - 01 addressable latch: q[addr] <= d; other bits hold.
  - 11 demux: q <= 8'h00 except q[addr] <= d.
  - 10 clear: q <= 8'h00.
- Counter cnt (only advances when scan=1):
  - If scan=1 and en=1: cnt <= cnt+1, wrapping 7 -> 0.
  - If scan=1, clr=1, en=0: cnt <= 0 (frame resync).
  - If scan=0: cnt holds its value. Toggling scan mid-frame neither resets nor advances cnt.
- Frame completion:
  - Condition: an edge with scan=1, en=1 and cnt=7.
  - On that edge, word <= the resulting q, which includes the just-written bit 7. In demux mode this is the single-hot value.
  - word_valid <= 1 for exactly that following cycle; otherwise word_valid <= 0.
  - word holds between frames.
- sel_out = cnt at all times (registered). The remote mux sees the address for the next bit one cycle after the write.
- Boundary cases:
  - Consecutive frames with en held high produce a word_valid pulse every 8 clocks.
  - en low mid-frame stalls cnt and the frame with no data loss.
  - rst asserted mid-frame discards the partial frame and pulses no word_valid.
- Simulation X handling: d=x writes x into q[addr] only. sel containing x while writing in direct mode drives all of q to x.

Test Plan:
- Reset: pulse rst=1 between edges with q previously 8'hA5 -> q=8'h00 immediately, before the next edge; word=0, sel_out=0, word_valid=0.
- Direct latch: scan=0, clr=0, en=1, write d=1 at sel=0,2,5,7 over 4 clocks, then en=0 for 2 clocks -> q=8'hA5 after the 4th edge and held.
- Demux and clear: q=8'hA5; {clr,en}=11, sel=3, d=1 -> q=8'h08. Then {clr,en}=10 -> q=8'h00. Then {clr,en}=00 -> q holds 8'h00.
- Scan frame: scan=1, clr=0, en=1, d sequence 1,0,1,0,0,1,0,1 (bit 0 first) -> sel_out counts 0..7 then 0; word=8'hA5 with word_valid=1 for exactly one cycle after the 8th edge.
- Stall and resync:
  - Drop en for 3 clocks at cnt=4 -> cnt stays 4, no word_valid; resuming completes the frame correctly.
  - {clr,en}=10 with scan=1 -> cnt=0, q=0.
- Back-to-back and reset mid-frame:
  - Two frames 8'h3C then 8'hC3 with en held high -> word_valid pulses 8 clocks apart with the correct words.
  - rst at cnt=5 -> no pulse; the next full frame starts at sel_out=0.

Source files
------------

// File: rtl/addr_latch_demux8.sv
// addr_latch_demux8: clocked 8-bit addressable latch / 1-to-8 demultiplexer.
// Rebuilds a byte serialized by a remote 8:1 mux. In scan mode an internal
// 3-bit counter walks the addresses, drives the remote mux selects through
// sel_out, and assembles each completed frame into word.
`timescale 1ns/1ps
module addr_latch_demux8 #(
  parameter int unsigned TPD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic       scan,
  input  logic [2:0] sel,
  input  logic       d,
  output logic [7:0] q,
  output logic [2:0] sel_out,
  output logic [7:0] word,
  output logic       word_valid
);

  logic [7:0] q_r;
  logic [7:0] q_nxt_s;
  logic [7:0] word_r;
  logic [7:0] word_nxt_s;
  logic [2:0] cnt_r;
  logic [2:0] cnt_nxt_s;
  logic [2:0] addr_s;
  logic       valid_r;
  logic       frame_done_s;

  // Effective address: internal counter in scan mode, external sel otherwise.
  always_comb begin
    addr_s = 3'd0;
    if (scan) begin
      addr_s = cnt_r;
    end else begin
      addr_s = sel;
    end
  end

  // Latch next state from the {clr,en} mode decode; an unknown direct-mode
  // address during a write poisons the whole latch in simulation.
  always_comb begin
    q_nxt_s = q_r;
    if (en && !scan && ((^sel) === 1'bx)) begin
      q_nxt_s = {8{1'bx}};
    end else begin
      case ({clr, en})
        2'b00: q_nxt_s = q_r;
        2'b01: q_nxt_s[addr_s] = d;
        2'b11: begin
          q_nxt_s         = 8'h00;
          q_nxt_s[addr_s] = d;
        end
        2'b10: q_nxt_s = 8'h00;
        default: q_nxt_s = q_r;
      endcase
    end
  end

  // Scan counter: advance on write, resync to zero on clear, frozen outside scan.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (scan && en) begin
      cnt_nxt_s = cnt_r + 3'd1;
    end else if (scan && clr) begin
      cnt_nxt_s = 3'd0;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Frame completes on the write of bit 7; capture the post-write latch value.
  always_comb begin
    frame_done_s = scan && en && (cnt_r == 3'd7);
    word_nxt_s   = word_r;
    if (frame_done_s) begin
      word_nxt_s = q_nxt_s;
    end else begin
      word_nxt_s = word_r;
    end
  end

  // State registers; asynchronous reset discards any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r     <= 8'h00;
      cnt_r   <= 3'd0;
      word_r  <= 8'h00;
      valid_r <= 1'b0;
    end else begin
      q_r     <= q_nxt_s;
      cnt_r   <= cnt_nxt_s;
      word_r  <= word_nxt_s;
      valid_r <= frame_done_s;
    end
  end

  // Output drive; the delay only exists for simulation when TPD is nonzero.
  generate
    if (TPD == 0) begin : g_nodly
      assign q          = q_r;
      assign sel_out    = cnt_r;
      assign word       = word_r;
      assign word_valid = valid_r;
    end else begin : g_dly
      assign #(TPD) q          = q_r;
      assign #(TPD) sel_out    = cnt_r;
      assign #(TPD) word       = word_r;
      assign #(TPD) word_valid = valid_r;
    end
  endgenerate

endmodule

// File: tb/tb_addr_latch_demux8.sv
// Self-checking bench for addr_latch_demux8: directed vector table,
// hand-written reset sequences, and randomized stimulus against a model.
`timescale 1ns/1ps
module tb_addr_latch_demux8;

  logic       clk;
  logic       rst;
  logic       en;
  logic       clr;
  logic       scan;
  logic [2:0] sel;
  logic       d;
  logic [7:0] q;
  logic [2:0] sel_out;
  logic [7:0] word;
  logic       word_valid;

  addr_latch_demux8 #(.TPD(0)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .scan(scan), .sel(sel), .d(d),
    .q(q), .sel_out(sel_out), .word(word), .word_valid(word_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       en;
    logic       scan;
    logic [2:0] sel;
    logic       d;
    logic [7:0] q;
    logic [2:0] so;
    logic [7:0] w;
    logic       v;
  } vec_t;

  vec_t vecs[64];
  int   nv;
  int   ncmp;
  int   nerr;

  // reference model state
  int   mq;
  int   mcnt;
  int   mword;
  int   mvalid;

  function automatic void add(input logic c, input logic e, input logic s,
                              input logic [2:0] a, input logic dd,
                              input logic [7:0] eq, input logic [2:0] eso,
                              input logic [7:0] ew, input logic ev);
    vecs[nv] = '{c, e, s, a, dd, eq, eso, ew, ev};
    nv = nv + 1;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    ncmp = ncmp + 1;
    if (act !== exp) begin
      nerr = nerr + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic e, input logic s,
                       input logic [2:0] a, input logic dd);
    clr = c; en = e; scan = s; sel = a; d = dd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] eq, input logic [2:0] eso,
                         input logic [7:0] ew, input logic ev);
    chk({tag, " q"}, q, eq);
    chk({tag, " sel_out"}, {5'd0, sel_out}, {5'd0, eso});
    chk({tag, " word"}, word, ew);
    chk({tag, " word_valid"}, {7'd0, word_valid}, {7'd0, ev});
  endtask

  // Behavioural model: one clock edge worth of the documented rules.
  function automatic void model_step(input logic c, input logic e, input logic s,
                                     input logic [2:0] a, input logic dd);
    int addr;
    int done;
    addr = s ? mcnt : int'(a);
    if (c) mq = 0;
    if (e) mq = (mq & ~(1 << addr)) | (int'(dd) << addr);
    done = (s && e && mcnt == 7) ? 1 : 0;
    if (s && e) mcnt = (mcnt + 1) % 8;
    else if (s && c) mcnt = 0;
    mvalid = done;
    if (done != 0) mword = mq;
  endfunction

  initial begin
    logic [7:0] fr;
    clk = 1'b0; rst = 1'b1; nv = 0; ncmp = 0; nerr = 0;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

    // direct latch
    add(0,1,0,3'd0,1, 8'h01,3'd0,8'h00,0);
    add(0,1,0,3'd2,1, 8'h05,3'd0,8'h00,0);
    add(0,1,0,3'd5,1, 8'h25,3'd0,8'h00,0);
    add(0,1,0,3'd7,1, 8'hA5,3'd0,8'h00,0);
    add(0,0,0,3'd1,1, 8'hA5,3'd0,8'h00,0);
    add(0,0,0,3'd4,1, 8'hA5,3'd0,8'h00,0);
    // demux, clear, memory
    add(1,1,0,3'd3,1, 8'h08,3'd0,8'h00,0);
    add(1,0,0,3'd3,1, 8'h00,3'd0,8'h00,0);
    add(0,0,0,3'd3,1, 8'h00,3'd0,8'h00,0);
    // scan frame A5
    add(0,1,1,3'd0,1, 8'h01,3'd1,8'h00,0);
    add(0,1,1,3'd0,0, 8'h01,3'd2,8'h00,0);
    add(0,1,1,3'd0,1, 8'h05,3'd3,8'h00,0);
    add(0,1,1,3'd0,0, 8'h05,3'd4,8'h00,0);
    add(0,1,1,3'd0,0, 8'h05,3'd5,8'h00,0);
    add(0,1,1,3'd0,1, 8'h25,3'd6,8'h00,0);
    add(0,1,1,3'd0,0, 8'h25,3'd7,8'h00,0);
    add(0,1,1,3'd0,1, 8'hA5,3'd0,8'hA5,1);
    add(0,0,1,3'd0,0, 8'hA5,3'd0,8'hA5,0);
    // stalled frame 5A
    add(0,1,1,3'd0,0, 8'hA4,3'd1,8'hA5,0);
    add(0,1,1,3'd0,1, 8'hA6,3'd2,8'hA5,0);
    add(0,1,1,3'd0,0, 8'hA2,3'd3,8'hA5,0);
    add(0,1,1,3'd0,1, 8'hAA,3'd4,8'hA5,0);
    add(0,0,1,3'd6,1, 8'hAA,3'd4,8'hA5,0);
    add(0,0,1,3'd6,1, 8'hAA,3'd4,8'hA5,0);
    add(0,0,1,3'd6,1, 8'hAA,3'd4,8'hA5,0);
    add(0,1,1,3'd0,1, 8'hBA,3'd5,8'hA5,0);
    add(0,1,1,3'd0,0, 8'h9A,3'd6,8'hA5,0);
    add(0,1,1,3'd0,1, 8'hDA,3'd7,8'hA5,0);
    add(0,1,1,3'd0,0, 8'h5A,3'd0,8'h5A,1);
    // resync
    add(0,1,1,3'd0,1, 8'h5B,3'd1,8'h5A,0);
    add(0,1,1,3'd0,1, 8'h5B,3'd2,8'h5A,0);
    add(1,0,1,3'd0,1, 8'h00,3'd0,8'h5A,0);
    // back-to-back 3C then C3
    add(0,1,1,3'd0,0, 8'h00,3'd1,8'h5A,0);
    add(0,1,1,3'd0,0, 8'h00,3'd2,8'h5A,0);
    add(0,1,1,3'd0,1, 8'h04,3'd3,8'h5A,0);
    add(0,1,1,3'd0,1, 8'h0C,3'd4,8'h5A,0);
    add(0,1,1,3'd0,1, 8'h1C,3'd5,8'h5A,0);
    add(0,1,1,3'd0,1, 8'h3C,3'd6,8'h5A,0);
    add(0,1,1,3'd0,0, 8'h3C,3'd7,8'h5A,0);
    add(0,1,1,3'd0,0, 8'h3C,3'd0,8'h3C,1);
    add(0,1,1,3'd0,1, 8'h3D,3'd1,8'h3C,0);
    add(0,1,1,3'd0,1, 8'h3F,3'd2,8'h3C,0);
    add(0,1,1,3'd0,0, 8'h3B,3'd3,8'h3C,0);
    add(0,1,1,3'd0,0, 8'h33,3'd4,8'h3C,0);
    add(0,1,1,3'd0,0, 8'h23,3'd5,8'h3C,0);
    add(0,1,1,3'd0,0, 8'h03,3'd6,8'h3C,0);
    add(0,1,1,3'd0,1, 8'h43,3'd7,8'h3C,0);
    add(0,1,1,3'd0,1, 8'hC3,3'd0,8'hC3,1);
    // demux in scan mode, then resync
    add(1,1,1,3'd5,1, 8'h01,3'd1,8'hC3,0);
    add(1,0,1,3'd5,1, 8'h00,3'd0,8'hC3,0);

    // power-on reset
    tick(); tick();
    rst = 1'b0;
    chk_all("reset", 8'h00, 3'd0, 8'h00, 1'b0);

    // directed table
    for (int i = 0; i < nv; i++) begin
      drive(vecs[i].clr, vecs[i].en, vecs[i].scan, vecs[i].sel, vecs[i].d);
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].q, vecs[i].so, vecs[i].w, vecs[i].v);
    end

    // asynchronous reset between edges with q = A5
    drive(1'b0, 1'b1, 1'b0, 3'd0, 1'b1); tick();
    drive(1'b0, 1'b1, 1'b0, 3'd2, 1'b1); tick();
    drive(1'b0, 1'b1, 1'b0, 3'd5, 1'b1); tick();
    drive(1'b0, 1'b1, 1'b0, 3'd7, 1'b1); tick();
    chk("pre-reset q", q, 8'hA5);
    #3 rst = 1'b1;
    #1 chk_all("async reset", 8'h00, 3'd0, 8'h00, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 3'd4, 1'b1);
    tick();
    chk_all("reset hold", 8'h00, 3'd0, 8'h00, 1'b0);
    rst = 1'b0;

    // reset mid-frame at cnt=5, then a full frame 96
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b1, 1'b1, 3'd0, 1'b1);
      tick();
      chk($sformatf("midframe%0d wv", k), {7'd0, word_valid}, 8'h00);
    end
    chk("midframe cnt", {5'd0, sel_out}, 8'h05);
    #3 rst = 1'b1;
    #1 rst = 1'b0;
    chk("midframe rst sel_out", {5'd0, sel_out}, 8'h00);
    chk("midframe rst wv", {7'd0, word_valid}, 8'h00);
    fr = 8'h96;
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b1, 1'b1, 3'd0, fr[k]);
      tick();
      chk($sformatf("frame96 b%0d sel_out", k), {5'd0, sel_out}, 8'((k + 1) % 8));
      chk($sformatf("frame96 b%0d wv", k), {7'd0, word_valid}, (k == 7) ? 8'h01 : 8'h00);
    end
    chk("frame96 word", word, 8'h96);
    drive(1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
    tick();
    chk("frame96 pulse end", {7'd0, word_valid}, 8'h00);

    // randomized run against the model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mq = 0; mcnt = 0; mword = 0; mvalid = 0;
    for (int n = 0; n < 600; n++) begin
      logic rc, re, rs, rd;
      logic [2:0] ra;
      rc = ($urandom_range(0, 7) == 0);
      re = ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 3) != 0);
      ra = 3'($urandom_range(0, 7));
      rd = 1'($urandom_range(0, 1));
      drive(rc, re, rs, ra, rd);
      model_step(rc, re, rs, ra, rd);
      tick();
      chk_all($sformatf("rand%0d", n), 8'(mq), 3'(mcnt), 8'(mword), 1'(mvalid));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
